// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: word-addressed memory model acting as the responder on an
// Ibex-style req/gnt/rvalid bus. Grants are throttled by a programmable grant
// delay and an outstanding-request limit, and responses come back in grant
// order after a fixed latency.
// Optional feature: define IBEX_MEM_RESP_STALL_EN to add an LFSR that injects
// pseudo-random grant back-pressure.
module ibex_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IdxW = $clog2(MemWords);

    logic [31:0]            mem_q [MemWords];

    logic [3:0]             waitCnt_q;
    logic [3:0]             waitCnt_d;
    logic [3:0]             outstanding_q;
    logic [3:0]             outstanding_d;

    logic [RespLatency-1:0] pipeValid_q;
    logic [RespLatency-1:0] pipeErr_q;
    logic [31:0]            pipeData_q [RespLatency];

    logic                   stall;
    logic                   grant;
    logic                   accessErr;
    logic                   respValid;
    logic                   delayDone;
    logic                   capacityOk;
    logic [29:0]            wordAddr;
    logic [IdxW-1:0]        wordIdx;

    assign wordAddr  = addr_i[31:2];
    assign wordIdx   = addr_i[IdxW+1:2];
    assign accessErr = (addr_i[1:0] != 2'b00) || ({2'b00, wordAddr} >= 32'(MemWords));

    assign respValid = pipeValid_q[RespLatency-1];
    assign delayDone = (waitCnt_q == 4'(GntDelay));

    // A response leaving this cycle frees its slot for a grant in the same
    // cycle, which is what lets back-to-back grants run when MaxOutstanding
    // equals RespLatency.
    assign capacityOk = (outstanding_q - {3'b000, respValid}) < 4'(MaxOutstanding);

    assign grant = req_i & delayDone & capacityOk & ~stall & ~rst_i;
    assign gnt_o = grant;

`ifdef IBEX_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // Free-running maximal-length LFSR (x^16+x^14+x^13+x^11+1) driving back-pressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0] & lfsr_q[3];
`else
    assign stall = 1'b0;
`endif

    // Next-state for the grant-delay counter and the outstanding-request count.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!req_i || grant) begin
            waitCnt_d = '0;
        end else if (!delayDone) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end
        outstanding_d = outstanding_q + {3'b000, grant} - {3'b000, respValid};
    end

    // Control state and the response pipeline; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waitCnt_q     <= '0;
            outstanding_q <= '0;
            pipeValid_q   <= '0;
            pipeErr_q     <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                pipeData_q[i] <= '0;
            end
        end else begin
            waitCnt_q      <= waitCnt_d;
            outstanding_q  <= outstanding_d;
            pipeValid_q[0] <= grant;
            pipeErr_q[0]   <= grant & accessErr;
            pipeData_q[0]  <= (grant && !we_i && !accessErr) ? mem_q[wordIdx] : 32'h0;
            for (int i = 1; i < RespLatency; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeErr_q[i]   <= pipeErr_q[i-1];
                pipeData_q[i]  <= pipeData_q[i-1];
            end
        end
    end

    // Byte-masked memory write on an error-free granted write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (grant && we_i && !accessErr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Pipeline stages carry zero data when empty, so only reset needs gating here.
    assign rvalid_o = respValid & ~rst_i;
    assign err_o    = pipeErr_q[RespLatency-1] & ~rst_i;
    assign rdata_o  = rst_i ? 32'h0 : pipeData_q[RespLatency-1];

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Testbench for ibex_mem_responder. Three instances with different timing
// parameters share one clock; a monitor pops the expected-response queue of
// each instance whenever that instance raises rvalid_o.
// Defining IBEX_MEM_RESP_STALL_EN adds a random-traffic run on instance 2.
module tb_ibex_mem_responder;

    localparam int MW = 64;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks;
    int errors;
    int cycle;
    int lastGrantCyc;
    int rvCount    [3];
    int grantCount [3];
`ifdef IBEX_MEM_RESP_STALL_EN
    int          stallSeen;
    logic [31:0] refMem [16];
`endif

    ibex_mem_responder #(.MemWords(MW), .GntDelay(2), .RespLatency(1), .MaxOutstanding(2)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]));

    ibex_mem_responder #(.MemWords(MW), .GntDelay(0), .RespLatency(3), .MaxOutstanding(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]));

    ibex_mem_responder #(.MemWords(MW), .GntDelay(0), .RespLatency(4), .MaxOutstanding(4)) dut2 (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
        .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .err_o(err[2]));

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp grants and responses.
    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    function automatic int latOf(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic void pushExp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t popExp(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qSize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expVal);
        checks = checks + 1;
        if (got !== expVal) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got %h expected %h (cycle %0d)", name, got, expVal, cycle);
        end
    endtask

    // Drive one request, hold it until granted, and queue its expected response.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] wd,
                                 input logic [31:0] expData, input logic expErr,
                                 output int waitCyc);
        exp_t e;
        logic granted;
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        be[d]    = b;
        wdata[d] = wd;
        waitCyc  = 0;
        granted  = 1'b0;
        while (!granted && waitCyc <= 200) begin
            @(negedge clk);
            if (gnt[d]) granted = 1'b1;
            else        waitCyc = waitCyc + 1;
        end
        if (!granted) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL grantTimeout dut%0d addr %h got no gnt required gnt", d, a);
            req[d] = 1'b0;
        end else begin
            e.data = expData;
            e.err  = expErr;
            e.cyc  = cycle;
            pushExp(d, e);
            lastGrantCyc  = cycle;
            grantCount[d] = grantCount[d] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        we[d]  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qSize(d) != 0 && n < 50) begin
            @(posedge clk);
            n = n + 1;
        end
        #1;
        checkOutput($sformatf("drain%0d", d), 32'(qSize(d)), 32'd0);
    endtask

    // Monitor: reset hold, idle-zero outputs, and in-order response scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst[d]) begin
                    checkOutput($sformatf("resetHold%0d", d),
                                {gnt[d], rvalid[d], err[d], |rdata[d], 28'h0}, 32'h0);
                end else begin
`ifdef IBEX_MEM_RESP_STALL_EN
                    if (d == 2 && req[2] && !gnt[2] && (qSize(2) - int'(rvalid[2])) < 4)
                        stallSeen = stallSeen + 1;
`endif
                    if (rvalid[d]) begin
                        rvCount[d] = rvCount[d] + 1;
                        if (qSize(d) == 0) begin
                            checks = checks + 1;
                            errors = errors + 1;
                            $display("[TB] FAIL unexpectedRvalid dut%0d got rvalid required none", d);
                        end else begin
                            e = popExp(d);
                            checkOutput($sformatf("rdata%0d", d), rdata[d], e.data);
                            checkOutput($sformatf("err%0d", d), {31'h0, err[d]}, {31'h0, e.err});
                            checkOutput($sformatf("latency%0d", d), 32'(cycle - e.cyc), 32'(latOf(d)));
                        end
                    end else begin
                        checkOutput($sformatf("idleZero%0d", d), {err[d], rdata[d][30:0]} | {1'b0, rdata[d][31], 30'h0}, 32'h0);
                    end
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int w;
        int prev;
        int rvBefore;
        checks = 0;
        errors = 0;
        lastGrantCyc = 0;
        for (int d = 0; d < 3; d++) begin
            rvCount[d] = 0;
            grantCount[d] = 0;
            be[d] = 4'h0;
            addr[d] = 32'h0;
            wdata[d] = 32'h0;
        end
`ifdef IBEX_MEM_RESP_STALL_EN
        stallSeen = 0;
`endif
        req = '0;
        we  = '0;
        rst = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = '0;

        // dut0: grant delay of 2, full write then read back.
        applyStimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, w);
`ifndef IBEX_MEM_RESP_STALL_EN
        checkOutput("gntDelayWrite", 32'(w), 32'd2);
`endif
        idle(0, 1);
        applyStimulus(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, w);
`ifndef IBEX_MEM_RESP_STALL_EN
        checkOutput("gntDelayRead", 32'(w), 32'd2);
`endif
        idle(0, 1);

        // dut0: partial byte-enable merge.
        applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, w);
        applyStimulus(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, w);
        applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, w);

        // dut0: error accesses leave memory alone; be=0 write is a no-op.
        applyStimulus(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, w);
        applyStimulus(0, 1'b0, 32'h2, 4'hF, 32'h0, 32'h0, 1'b1, w);
        applyStimulus(0, 1'b0, 32'(MW * 4), 4'hF, 32'h0, 32'h0, 1'b1, w);
        applyStimulus(0, 1'b1, 32'h12, 4'hF, 32'h0, 32'h0, 1'b1, w);
        applyStimulus(0, 1'b1, 32'(MW * 4), 4'hF, 32'h0, 32'h0, 1'b1, w);
        applyStimulus(0, 1'b1, 32'h10, 4'h0, 32'h0, 32'h0, 1'b0, w);
        applyStimulus(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, w);
        applyStimulus(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, w);
        idle(0, 1);
        drain(0);

        // dut1: one outstanding, latency 3, request held high.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 32'(i * 4), 4'hF, 32'h50000000 + 32'(i), 32'h0, 1'b0, w);
            checkOutput($sformatf("maxOutstanding%0d", i), 32'(qSize(1) <= 1), 32'd1);
`ifndef IBEX_MEM_RESP_STALL_EN
            if (i > 0) checkOutput($sformatf("grantSpacing%0d", i), 32'(lastGrantCyc - prev), 32'd3);
`endif
            prev = lastGrantCyc;
        end
        applyStimulus(1, 1'b0, 32'h8, 4'hF, 32'h0, 32'h50000002, 1'b0, w);
        idle(1, 1);
        drain(1);

        // dut2: back-to-back writes then reads with latency 4, four outstanding.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 1'b1, 32'(i * 4), 4'hF, 32'h10000000 + 32'(i * 32'h111), 32'h0, 1'b0, w);
`ifndef IBEX_MEM_RESP_STALL_EN
            checkOutput($sformatf("b2bWrite%0d", i), 32'(w), 32'd0);
`endif
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, 32'h10000000 + 32'(i * 32'h111), 1'b0, w);
`ifndef IBEX_MEM_RESP_STALL_EN
            checkOutput($sformatf("b2bRead%0d", i), 32'(w), 32'd0);
`endif
        end
        idle(2, 1);
        drain(2);

        // dut2: reset one cycle after a grant discards the response, keeps memory.
        applyStimulus(2, 1'b0, 32'hC, 4'hF, 32'h0, 32'h10000333, 1'b0, w);
        rst[2] = 1'b1;
        req[2] = 1'b0;
        q2.delete();
        rvBefore = rvCount[2];
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("noRvalidAfterReset", 32'(rvCount[2] - rvBefore), 32'd0);
        applyStimulus(2, 1'b0, 32'hC, 4'hF, 32'h0, 32'h10000333, 1'b0, w);
        idle(2, 1);
        drain(2);

`ifdef IBEX_MEM_RESP_STALL_EN
        // dut2: random traffic under LFSR back-pressure against a reference model.
        for (int i = 0; i < 16; i++) begin
            refMem[i] = 32'hA5000000 + 32'(i);
            applyStimulus(2, 1'b1, 32'(i * 4), 4'hF, refMem[i], 32'h0, 1'b0, w);
        end
        for (int n = 0; n < 1000; n++) begin
            int          sel;
            int          idx;
            logic        wr;
            logic        isErr;
            logic [3:0]  rb;
            logic [31:0] ra;
            logic [31:0] rd;
            logic [31:0] ex;
            sel = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 15));
            wr  = 1'($urandom_range(0, 1));
            rb  = 4'($urandom);
            rd  = $urandom;
            if (sel == 0)      ra = 32'(idx * 4) + 32'($urandom_range(1, 3));
            else if (sel == 1) ra = 32'(MW * 4) + 32'(idx * 4);
            else               ra = 32'(idx * 4);
            isErr = (sel <= 1);
            ex = 32'h0;
            if (wr) begin
                if (!isErr) begin
                    for (int b = 0; b < 4; b++)
                        if (rb[b]) refMem[idx][8*b +: 8] = rd[8*b +: 8];
                end
            end else if (!isErr) begin
                ex = refMem[idx];
            end
            applyStimulus(2, wr, ra, rb, rd, ex, isErr, w);
            if (sel == 2) idle(2, 1);
        end
        idle(2, 1);
        drain(2);
        checkOutput("stallObserved", 32'(stallSeen > 0), 32'd1);
        checkOutput("answeredOnce", 32'(rvCount[2]), 32'(grantCount[2] - 1));
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
